// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - control bus from the stopwatch FSM to the BCD counter/display datapath
//
// Signals (master = stopwatch_ctrl, slave = datapath):
//   tick_o   1  one-cycle count strobe
//   clear_o  1  one-cycle strobe, counter to 00.00
//   inc_o    1  one-cycle strobe, increment digit sel_o (mod 10)
//   sel_o    2  digit under edit, 0 = hex0 .. 3 = hex3
//   state_o  2  00 STOP, 01 RUN, 10 SET
//   blink_o  1  1 = blank the digit selected by sel_o
interface stopwatch_ctrl_if;
    logic       tick_o;
    logic       clear_o;
    logic       inc_o;
    logic [1:0] sel_o;
    logic [1:0] state_o;
    logic       blink_o;

    modport master (
        output tick_o, clear_o, inc_o, sel_o, state_o, blink_o
    );

    modport slave (
        input tick_o, clear_o, inc_o, sel_o, state_o, blink_o
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM with button synchronise/debounce and datapath strobes
//
// Ports:
//   clk100_i      in   system clock
//   rst_i         in   synchronous active-high reset
//   start_stop_i  in   active-low button, asynchronous
//   set_i         in   active-low button, asynchronous
//   change_i      in   active-low button, asynchronous
//   dp            stopwatch_ctrl_if.master: tick/clear/inc strobes, sel, state, blink
//
// Optional feature macro: STOPWATCH_CTRL_BLINK_EN (blink the edited digit in SET).
module stopwatch_ctrl #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int TICK_HZ      = 100,
    parameter int DEBOUNCE_CYC = 4,
    parameter int BLINK_HZ     = 2
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic start_stop_i,
    input  logic set_i,
    input  logic change_i,
    stopwatch_ctrl_if.master dp
);

    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam int CNT_W    = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_SET  = 2'b10;

    // Button index: 0 = start_stop, 1 = set, 2 = change (also the priority order)
    logic [2:0]       btn_raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [2:0]       stable_d;
    logic [2:0]       ev;
    logic [CNT_W-1:0] db_cnt [3];

    assign btn_raw = {change_i, set_i, start_stop_i};

    // Debounce: the stable level follows the synced level only after DEBOUNCE_CYC
    // consecutive disagreeing samples. Press events are registered once more so the
    // FSM reacts DEBOUNCE_CYC+3 edges after the pin falls.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            sync1    <= '1;
            sync2    <= '1;
            stable   <= '1;
            stable_d <= '1;
            ev       <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            ev       <= stable_d & ~stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0]       state, state_n;
    logic [1:0]       sel, sel_n;
    logic [PRE_W-1:0] presc, presc_n, presc_inc;
    logic             tick_q, tick_n;
    logic             clear_q, clear_n;
    logic             inc_q, inc_n;

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        presc_n   = presc;
        tick_n    = 1'b0;
        clear_n   = 1'b0;
        inc_n     = 1'b0;
        presc_inc = (presc == PRE_LAST) ? '0 : presc + 1'b1;
        case (state)
            ST_STOP: begin
                if (ev[0]) begin
                    state_n = ST_RUN;
                end else if (ev[1]) begin
                    state_n = ST_SET;
                    sel_n   = 2'd0;
                end else if (ev[2]) begin
                    clear_n = 1'b1;
                    presc_n = '0;
                end
            end
            ST_RUN: begin
                // The exit edge neither advances the prescaler nor ticks, so a
                // stopped watch resumes exactly where it left off.
                if (ev[0]) begin
                    state_n = ST_STOP;
                end else begin
                    presc_n = presc_inc;
                    tick_n  = (presc_inc == PRE_LAST);
                end
            end
            ST_SET: begin
                if (ev[0]) begin
                    state_n = ST_STOP;
                    sel_n   = 2'd0;
                end else if (ev[1]) begin
                    if (sel == 2'd3) begin
                        state_n = ST_STOP;
                        sel_n   = 2'd0;
                    end else begin
                        sel_n = sel + 2'd1;
                    end
                end else if (ev[2]) begin
                    inc_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_STOP;
                sel_n   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            state   <= ST_STOP;
            sel     <= 2'd0;
            presc   <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            presc   <= presc_n;
            tick_q  <= tick_n;
            clear_q <= clear_n;
            inc_q   <= inc_n;
        end
    end

    assign dp.tick_o  = tick_q;
    assign dp.clear_o = clear_q;
    assign dp.inc_o   = inc_q;
    assign dp.sel_o   = sel;
    assign dp.state_o = state;

`ifdef STOPWATCH_CTRL_BLINK_EN
    localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BL_W       = $clog2(BLINK_HALF + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_q;

    // Restart the blink phase whenever SET is left or the edited digit moves,
    // so a freshly selected digit is always shown first.
    always_ff @(posedge clk100_i) begin
        if (rst_i || (state_n != ST_SET) || (sel_n != sel)) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign dp.blink_o = blink_q;
`else
    // BLINK_HZ has no effect without blinking; the digit is never blanked.
    if (BLINK_HZ > 0) begin : g_no_blink
        assign dp.blink_o = 1'b0;
    end else begin : g_no_blink_zero_hz
        assign dp.blink_o = 1'b0;
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic set_n;
    logic chg_n;

    int ncmp = 0;
    int nerr = 0;
    logic seen;

    stopwatch_ctrl_if dp_if ();

    stopwatch_ctrl #(
        .CLK_FREQ_HZ (100_000_000),
        .TICK_HZ     (10_000_000),
        .DEBOUNCE_CYC(4),
        .BLINK_HZ    (5_000_000)
    ) dut (
        .clk100_i    (clk),
        .rst_i       (rst),
        .start_stop_i(ss_n),
        .set_i       (set_n),
        .change_i    (chg_n),
        .dp          (dp_if)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 start_stop, 1 set, 2 change
    task automatic drive_btn(input int which, input logic lvl);
        case (which)
            0:       ss_n  = lvl;
            1:       set_n = lvl;
            default: chg_n = lvl;
        endcase
    endtask

    task automatic press_full(input int which);
        drive_btn(which, 1'b0);
        step(10);
        drive_btn(which, 1'b1);
        step(10);
    endtask

    initial begin
        rst   = 1'b1;
        ss_n  = 1'b1;
        set_n = 1'b1;
        chg_n = 1'b1;
        step(3);
        rst = 1'b0;

        // reset state
        check("rst_state", dp_if.state_o, 2'b00);
        check("rst_sel",   dp_if.sel_o,   2'd0);
        check("rst_tick",  dp_if.tick_o,  1'b0);
        check("rst_clear", dp_if.clear_o, 1'b0);
        check("rst_inc",   dp_if.inc_o,   1'b0);
        check("rst_blink", dp_if.blink_o, 1'b0);

        // 1: idle for 1000 cycles
        seen = 1'b0;
        repeat (1000) begin
            step(1);
            seen = seen | dp_if.tick_o | dp_if.clear_o | dp_if.inc_o | (dp_if.state_o != 2'b00);
        end
        check("idle_quiet", seen, 1'b0);

        // 2: start, tick period 10, stop, resume mid-period
        ss_n = 1'b0;
        step(7);
        check("run_k6_state", dp_if.state_o, 2'b00);
        step(1);
        check("run_k7_state", dp_if.state_o, 2'b01);
        check("run_k7_tick",  dp_if.tick_o,  1'b0);
        step(2);
        ss_n = 1'b1;
        step(6);
        check("tick_e8", dp_if.tick_o, 1'b0);
        step(1);
        check("tick_e9", dp_if.tick_o, 1'b1);
        step(1);
        check("tick_e10", dp_if.tick_o, 1'b0);
        step(9);
        check("tick_e19", dp_if.tick_o, 1'b1);

        ss_n = 1'b0;
        step(7);
        check("stop_k6_state", dp_if.state_o, 2'b01);
        step(1);
        check("stop_k7_state", dp_if.state_o, 2'b00);
        check("stop_k7_tick",  dp_if.tick_o,  1'b0);
        step(2);
        ss_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            step(1);
            seen = seen | dp_if.tick_o;
        end
        check("stop_no_tick", seen, 1'b0);

        // prescaler held at 6: resumes with tick 3 edges after re-entering RUN
        ss_n = 1'b0;
        step(8);
        check("resume_state", dp_if.state_o, 2'b01);
        step(2);
        ss_n = 1'b1;
        check("resume_r2_tick", dp_if.tick_o, 1'b0);
        step(1);
        check("resume_r3_tick", dp_if.tick_o, 1'b1);
        step(10);
        check("resume_r13_tick", dp_if.tick_o, 1'b1);

        ss_n = 1'b0;
        step(8);
        check("stop2_state", dp_if.state_o, 2'b00);
        step(2);
        ss_n = 1'b1;
        step(10);

        // 3: SET mode, increment and digit selection
        set_n = 1'b0;
        step(8);
        check("set_state", dp_if.state_o, 2'b10);
        check("set_sel",   dp_if.sel_o,   2'd0);
`ifndef STOPWATCH_CTRL_BLINK_EN
        check("set_blink", dp_if.blink_o, 1'b0);
`endif
        step(2);
        set_n = 1'b1;
        step(10);

        chg_n = 1'b0;
        step(7);
        check("inc_k6", dp_if.inc_o, 1'b0);
        step(1);
        check("inc_k7",     dp_if.inc_o, 1'b1);
        check("inc_k7_sel", dp_if.sel_o, 2'd0);
        step(1);
        check("inc_k8", dp_if.inc_o, 1'b0);
        step(1);
        chg_n = 1'b1;
        step(10);

        press_full(1);
        check("sel1", dp_if.sel_o, 2'd1);
        press_full(1);
        check("sel2", dp_if.sel_o, 2'd2);
        press_full(1);
        check("sel3", dp_if.sel_o, 2'd3);
        check("sel3_state", dp_if.state_o, 2'b10);
        press_full(1);
        check("sel_wrap_state", dp_if.state_o, 2'b00);
        check("sel_wrap_sel",   dp_if.sel_o,   2'd0);

        // 4: short change pulse in SET, then clear in STOP
        press_full(1);
        chg_n = 1'b0;
        step(3);
        chg_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            step(1);
            seen = seen | dp_if.inc_o;
        end
        check("short_no_inc", seen, 1'b0);
        check("short_state",  dp_if.state_o, 2'b10);
        press_full(0);
        check("set_exit_state", dp_if.state_o, 2'b00);

        chg_n = 1'b0;
        step(7);
        check("clear_k6", dp_if.clear_o, 1'b0);
        step(1);
        check("clear_k7", dp_if.clear_o, 1'b1);
        step(1);
        check("clear_k8", dp_if.clear_o, 1'b0);
        check("clear_state", dp_if.state_o, 2'b00);
        step(1);
        chg_n = 1'b1;
        step(10);

        // 5: start_stop and change together in SET, sel at 1
        press_full(1);
        press_full(1);
        check("prio_pre_sel", dp_if.sel_o, 2'd1);
        ss_n  = 1'b0;
        chg_n = 1'b0;
        seen  = 1'b0;
        repeat (7) begin
            step(1);
            seen = seen | dp_if.inc_o;
        end
        check("prio_k6_state", dp_if.state_o, 2'b10);
        step(1);
        check("prio_state", dp_if.state_o, 2'b00);
        check("prio_sel",   dp_if.sel_o,   2'd0);
        repeat (10) begin
            step(1);
            seen = seen | dp_if.inc_o;
        end
        ss_n  = 1'b1;
        chg_n = 1'b1;
        step(10);
        check("prio_no_inc", seen, 1'b0);

        // 6: reset mid-period in RUN clears state and prescaler
        ss_n = 1'b0;
        step(8);
        check("rr_run", dp_if.state_o, 2'b01);
        step(2);
        ss_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        check("rr_state", dp_if.state_o, 2'b00);
        check("rr_tick",  dp_if.tick_o,  1'b0);
        rst = 1'b0;
        step(10);
        ss_n = 1'b0;
        step(8);
        check("rr2_run", dp_if.state_o, 2'b01);
        step(2);
        ss_n = 1'b1;
        step(2);
        check("rr2_e4_tick", dp_if.tick_o, 1'b0);
        step(5);
        check("rr2_e9_tick", dp_if.tick_o, 1'b1);

        // button held low through reset deassertion
        rst  = 1'b1;
        ss_n = 1'b0;
        step(2);
        rst = 1'b0;
        check("held_rst_state", dp_if.state_o, 2'b00);
        step(7);
        check("held_k6_state", dp_if.state_o, 2'b00);
        step(1);
        check("held_k7_state", dp_if.state_o, 2'b01);
        ss_n = 1'b1;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
